// File: rtl/c_arb_merge_fifo_sync_if.sv
// Producer-side and consumer-side handshake bundle for the arbitrated merge FIFO.
// slave = the merge block itself, master = whatever drives producers and consumer.
interface c_arb_merge_fifo_sync_if #(
    parameter int N_CH  = 2,
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
);
    localparam int SRC_W = $clog2(N_CH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [N_CH-1:0]       i_drive;
    logic [N_CH*WIDTH-1:0] i_data;
    logic [N_CH-1:0]       o_free;
    logic                  o_driveNext;
    logic [WIDTH-1:0]      o_dataNext;
    logic [SRC_W-1:0]      o_srcNext;
    logic                  i_freeNext;
    logic [DEPTH-1:0]      o_fire;
    logic [CNT_W-1:0]      o_count;

    modport slave (
        input  i_drive, i_data, i_freeNext,
        output o_free, o_driveNext, o_dataNext, o_srcNext, o_fire, o_count
    );

    modport master (
        output i_drive, i_data, i_freeNext,
        input  o_free, o_driveNext, o_dataNext, o_srcNext, o_fire, o_count
    );
endinterface

// File: rtl/c_arb_merge_fifo_sync.sv
// Round-robin merge of N_CH producers into a source-tagged DEPTH-entry FIFO.
// Latency 1 cycle accept-to-head; no push while full, consumer ready never reaches o_free.
module c_arb_merge_fifo_sync #(
    parameter int N_CH  = 2,
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    c_arb_merge_fifo_sync_if.slave io_bus
);
    localparam int SRC_W = $clog2(N_CH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] L_DEPTH    = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] L_PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [SRC_W-1:0] L_CH_LAST  = SRC_W'(N_CH - 1);
    localparam logic [SRC_W:0]   L_N_CH     = (SRC_W + 1)'(N_CH);

    logic [CNT_W-1:0] r_cnt;
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [SRC_W-1:0] r_rr;
    logic [DEPTH-1:0] r_fire;
    logic [WIDTH-1:0] r_mem_dat [DEPTH];
    logic [SRC_W-1:0] r_mem_src [DEPTH];

    logic [SRC_W:0]   w_sum;
    logic [SRC_W-1:0] w_idx;
    logic [SRC_W-1:0] w_gnt;
    logic             w_found;
    logic             w_elig;
    logic             w_push;
    logic             w_pop;
    logic [N_CH-1:0]  w_free;

    // Search channels starting at the round-robin pointer, wrapping modulo N_CH.
    always_comb begin
        w_sum   = '0;
        w_idx   = '0;
        w_gnt   = '0;
        w_found = 1'b0;
        for (int j = 0; j < N_CH; j++) begin
            w_sum = {1'b0, r_rr} + (SRC_W + 1)'(j);
            if (w_sum >= L_N_CH) begin
                w_sum = w_sum - L_N_CH;
            end
            w_idx = w_sum[SRC_W-1:0];
            if (!w_found && io_bus.i_drive[w_idx]) begin
                w_found = 1'b1;
                w_gnt   = w_idx;
            end
        end
    end

    assign w_elig = !rst && (r_cnt != L_DEPTH);
    assign w_push = w_elig && w_found;
    assign w_pop  = (r_cnt != '0) && io_bus.i_freeNext;
    assign w_free = w_push ? (N_CH'(1) << w_gnt) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_wr   <= '0;
            r_rd   <= '0;
            r_rr   <= '0;
            r_fire <= '0;
        end else begin
            if (w_push) begin
                r_rr <= (w_gnt == L_CH_LAST) ? '0 : w_gnt + 1'b1;
                r_wr <= (r_wr == L_PTR_LAST) ? '0 : r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= (r_rd == L_PTR_LAST) ? '0 : r_rd + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
            r_fire <= w_push ? (DEPTH'(1) << r_wr) : '0;
        end
    end

    // Storage needs no reset: contents are only observed through a nonzero count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_dat[r_wr] <= io_bus.i_data[w_gnt*WIDTH +: WIDTH];
            r_mem_src[r_wr] <= w_gnt;
        end
    end

    assign io_bus.o_free      = w_free;
    assign io_bus.o_driveNext = (r_cnt != '0);
    assign io_bus.o_dataNext  = r_mem_dat[r_rd];
    assign io_bus.o_srcNext   = r_mem_src[r_rd];
    assign io_bus.o_fire      = r_fire;
    assign io_bus.o_count     = r_cnt;
endmodule
